// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch/countdown timer family.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam logic [3:0]  BCD_MAX             = 4'd9;
   localparam int unsigned DEFAULT_CLOCK_SPEED = 50_000_000;

   // Out-of-range BCD inputs saturate at 9 so a digit never leaves 0..9.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] val);
      return (val > BCD_MAX) ? BCD_MAX : val;
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between the switch/key logic and the countdown timer.
interface countdown_timer_if;
   logic       load;
   logic [3:0] loadS;
   logic [3:0] loadDs;
   logic [3:0] loadCs;
   logic       run;
   logic [3:0] sCount;
   logic [3:0] dsCount;
   logic [3:0] csCount;
   logic       running;
   logic       expired;

   modport master (
      output load, loadS, loadDs, loadCs, run,
      input  sCount, dsCount, csCount, running, expired
   );

   modport slave (
      input  load, loadS, loadDs, loadCs, run,
      output sCount, dsCount, csCount, running, expired
   );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit that loads (with clamp) and decrements, wrapping 0 -> 9 with a borrow.
module bcd_down_digit
   import timer_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] loadVal,
   input  logic       dec,
   output logic [3:0] digit,
   output logic       borrowOut
);

   assign borrowOut = dec & (digit == 4'd0);

   always_ff @(posedge clock) begin
      if (reset) begin
         digit <= 4'd0;
      end else if (load) begin
         digit <= bcd_clamp(loadVal);
      end else if (dec) begin
         digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: prescaler, run/pause/expire FSM and three cascaded BCD digits.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned CLOCK_SPEED = DEFAULT_CLOCK_SPEED,
   parameter int unsigned TICK_HZ     = 100
) (
   input  logic              clock,
   input  logic              reset,
   countdown_timer_if.slave  bus
);

   localparam int unsigned DIV = CLOCK_SPEED / TICK_HZ;
   localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

   state_t        state;
   logic [PW-1:0] presc;
   logic [3:0]    s_digit;
   logic [3:0]    ds_digit;
   logic [3:0]    cs_digit;
   logic          cs_borrow;
   logic          ds_borrow;
   logic          s_borrow;
   logic          tick_c;
   logic          zero_c;
   logic          last_tick_c;

   assign tick_c      = (state == RUN) && (presc == PW'(DIV - 1));
   assign zero_c      = (s_digit == 4'd0) && (ds_digit == 4'd0) && (cs_digit == 4'd0);
   // The tick taking 0.01 to 0.00 expires instead of ever borrowing out of seconds.
   assign last_tick_c = tick_c && (s_digit == 4'd0) && (ds_digit == 4'd0) && (cs_digit == 4'd1);

   bcd_down_digit u_cs (
      .clock     (clock),
      .reset     (reset),
      .load      (bus.load),
      .loadVal   (bus.loadCs),
      .dec       (tick_c),
      .digit     (cs_digit),
      .borrowOut (cs_borrow)
   );

   bcd_down_digit u_ds (
      .clock     (clock),
      .reset     (reset),
      .load      (bus.load),
      .loadVal   (bus.loadDs),
      .dec       (cs_borrow),
      .digit     (ds_digit),
      .borrowOut (ds_borrow)
   );

   bcd_down_digit u_s (
      .clock     (clock),
      .reset     (reset),
      .load      (bus.load),
      .loadVal   (bus.loadS),
      .dec       (ds_borrow),
      .digit     (s_digit),
      .borrowOut (s_borrow)
   );

   // State, prescaler and status flags; load outranks any tick or run change.
   always_ff @(posedge clock) begin
      if (reset || bus.load) begin
         state       <= IDLE;
         presc       <= '0;
         bus.running <= 1'b0;
         bus.expired <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               presc <= '0;
               if (bus.run && !zero_c) begin
                  state       <= RUN;
                  bus.running <= 1'b1;
               end
            end
            RUN: begin
               presc <= tick_c ? '0 : presc + PW'(1);
               if (last_tick_c) begin
                  state       <= EXPIRED;
                  bus.running <= 1'b0;
                  bus.expired <= 1'b1;
               end else if (!bus.run) begin
                  state       <= PAUSED;
                  bus.running <= 1'b0;
               end
            end
            PAUSED: begin
               if (bus.run) begin
                  state       <= RUN;
                  bus.running <= 1'b1;
               end
            end
            EXPIRED: begin
               presc <= '0;
            end
            default: begin
               state       <= IDLE;
               presc       <= '0;
               bus.running <= 1'b0;
               bus.expired <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sCount  = s_digit;
   assign bus.dsCount = ds_digit;
   assign bus.csCount = cs_digit;

   logic unused_c;
   assign unused_c = s_borrow;

endmodule
